// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer: locks to the slot-0 start-of-frame marker
// and delivers one complete 4-channel word per frame on out_data.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_sof,
   output logic [4*WIDTH-1:0] out_data,
   output logic               out_valid,
   output logic               frame_err,
   output logic               locked,
   output logic [1:0]         slot
);

   typedef enum logic [0:0] {StHunt, StLock} state_e;

   state_e             state_q, state_d;
   logic [1:0]         slot_q, slot_d;
   logic [WIDTH-1:0]   shadow0_q, shadow0_d;
   logic [WIDTH-1:0]   shadow1_q, shadow1_d;
   logic [WIDTH-1:0]   shadow2_q, shadow2_d;
   logic [4*WIDTH-1:0] out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               frame_err_q, frame_err_d;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      shadow0_d   = shadow0_q;
      shadow1_d   = shadow1_q;
      shadow2_d   = shadow2_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      frame_err_d = 1'b0;

      if (in_valid) begin
         unique case (state_q)
            StHunt: begin
               if (in_sof) begin
                  shadow0_d = in_data;
                  slot_d    = 2'd1;
                  state_d   = StLock;
               end
            end
            StLock: begin
               if (in_sof) begin
                  // An SOF mid-frame abandons the partial frame and restarts at slot 0.
                  frame_err_d = (slot_q != 2'd0);
                  shadow0_d   = in_data;
                  slot_d      = 2'd1;
               end else if (slot_q == 2'd0) begin
                  frame_err_d = 1'b1;
                  state_d     = StHunt;
                  slot_d      = 2'd0;
               end else if (slot_q == 2'd3) begin
                  out_data_d  = {in_data, shadow2_q, shadow1_q, shadow0_q};
                  out_valid_d = 1'b1;
                  slot_d      = 2'd0;
               end else begin
                  if (slot_q == 2'd1) begin
                     shadow1_d = in_data;
                  end else begin
                     shadow2_d = in_data;
                  end
                  slot_d = slot_q + 2'd1;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StHunt;
         slot_q      <= 2'd0;
         shadow0_q   <= '0;
         shadow1_q   <= '0;
         shadow2_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         shadow0_q   <= shadow0_d;
         shadow1_q   <= shadow1_d;
         shadow2_q   <= shadow2_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign locked    = (state_q == StLock);
   assign slot      = slot_q;

endmodule
